// File: rtl/apb_i2c_arb_pkg.sv
// Shared state encoding, default bus geometry and index-width helper for the
// APB requester arbiter in front of the I2C master core.
package apb_i2c_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  localparam int ARB_ADDR_W  = 8;
  localparam int ARB_DATA_W  = 8;
  localparam int ARB_TIMEOUT = 16;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first active request found after
// i_last (wrapping) wins; the result is one-hot plus its binary index.
module rr_arbiter
  import apb_i2c_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = i_last;
    // Walk the ring once, starting just after the previous owner.
    for (int k = 0; k < NREQ; k++) begin
      w_cand = (w_cand == IDX_W'(NREQ - 1)) ? '0 : w_cand + IDX_W'(1);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/apb_i2c_arbiter.sv
// Shares the I2C core's single APB slave port among NREQ requesters: one
// command per grant, full setup/access transfer, response or timeout back.
module apb_i2c_arbiter
  import apb_i2c_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic                   pclk,
  input  logic                   PRESET,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   PSELx,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_W-1:0]      PADDR,
  output logic [DATA_W-1:0]      PWDATA,
  input  logic                   PREADY,
  input  logic [DATA_W-1:0]      PRDATA
);

  localparam int IDX_W = idx_width(NREQ);
  localparam int CNT_W = idx_width(TIMEOUT);

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic             w_accept;
  logic             w_timeout;

  logic [NREQ-1:0]  w_gnt;
  logic [IDX_W-1:0] w_win_idx;
  logic [IDX_W-1:0] r_last_gnt;
  logic [IDX_W-1:0] r_owner;
  logic [CNT_W-1:0] r_wait;

  logic             r_psel;
  logic             r_penable;
  logic             r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [NREQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic             r_rsp_err;

  logic [ADDR_W-1:0] w_addr  [NREQ];
  logic [DATA_W-1:0] w_wdata [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req  (req_valid),
    .i_last (r_last_gnt),
    .o_gnt  (w_gnt),
    .o_idx  (w_win_idx)
  );

  always_ff @(posedge pclk or posedge PRESET) begin
    if (PRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          w_state_next = ST_RESP;
        end else if (r_wait == CNT_W'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Grant is only offered while idle; reset masks it so nothing can be taken.
  assign req_ready = (r_state == ST_IDLE && !PRESET) ? w_gnt : '0;

  always_ff @(posedge pclk or posedge PRESET) begin
    if (PRESET) begin
      r_last_gnt  <= IDX_W'(NREQ - 1);
      r_owner     <= '0;
      r_wait      <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      // Bus strobes are registered from the next state so they line up with it.
      r_psel      <= (w_state_next == ST_SETUP) || (w_state_next == ST_ACCESS);
      r_penable   <= (w_state_next == ST_ACCESS);
      r_rsp_valid <= '0;

      if (w_accept) begin
        r_owner  <= w_win_idx;
        r_pwrite <= req_write[w_win_idx];
        r_paddr  <= w_addr[w_win_idx];
        r_pwdata <= w_wdata[w_win_idx];
      end

      if (r_state == ST_ACCESS) begin
        if (w_state_next == ST_RESP) begin
          r_rsp_valid[r_owner] <= 1'b1;
          r_last_gnt           <= r_owner;
          r_rsp_err            <= w_timeout;
          r_rsp_rdata          <= (!w_timeout && !r_pwrite) ? PRDATA : '0;
        end else begin
          r_wait <= r_wait + CNT_W'(1);
        end
      end

      if (r_state == ST_RESP) begin
        r_wait <= '0;
      end
    end
  end

  assign PSELx     = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_i2c_arbiter.sv
// Bench for apb_i2c_arbiter: transaction-timeline model checked every cycle,
// directed scenarios pinned by literals, then randomized traffic with resets.
module tb_apb_i2c_arbiter;

  localparam int NREQ    = 2;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic                   pclk      = 1'b0;
  logic                   PRESET    = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_write = '0;
  logic [NREQ*ADDR_W-1:0] req_addr  = '0;
  logic [NREQ*DATA_W-1:0] req_wdata = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;
  logic                   PSELx;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [ADDR_W-1:0]      PADDR;
  logic [DATA_W-1:0]      PWDATA;
  logic                   PREADY    = 1'b0;
  logic [DATA_W-1:0]      PRDATA    = '0;

  always #5 pclk = ~pclk;

  apb_i2c_arbiter #(
    .NREQ    (NREQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .pclk      (pclk),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSELx     (PSELx),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a transfer is described by its age in cycles since acceptance
  // (1 = setup, 2.. = access) and the age at which the response is due.
  bit                m_busy    = 1'b0;
  int                m_age     = 0;
  int                m_done_at = -1;
  int                m_owner   = 0;
  int                m_last    = NREQ - 1;
  bit                m_write   = 1'b0;
  logic [ADDR_W-1:0] m_paddr   = '0;
  logic [DATA_W-1:0] m_pwdata  = '0;
  logic [DATA_W-1:0] m_rdata   = '0;
  bit                m_err     = 1'b0;
  logic [NREQ-1:0]   m_acc_mask = '0;
  int                acc_cycle = 0;

  int log_owner[$];
  int log_acc[$];
  int log_lat[$];
  int log_rdata[$];
  int log_err[$];

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (last + k) % NREQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  logic [NREQ-1:0] e_ready;
  logic [NREQ-1:0] e_rsp;
  logic            e_psel;
  logic            e_pen;
  int              win;

  always @(negedge pclk) begin
    #1;
    cyc++;
    m_acc_mask = '0;
    if (PRESET) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
      chk("rst_rsp_err",   32'(rsp_err), 0);
      chk("rst_psel",      32'(PSELx), 0);
      chk("rst_penable",   32'(PENABLE), 0);
      chk("rst_pwrite",    32'(PWRITE), 0);
      chk("rst_paddr",     32'(PADDR), 0);
      chk("rst_pwdata",    32'(PWDATA), 0);
      m_busy   = 1'b0;
      m_last   = NREQ - 1;
      m_write  = 1'b0;
      m_paddr  = '0;
      m_pwdata = '0;
    end else begin
      e_ready = '0;
      e_rsp   = '0;
      e_psel  = 1'b0;
      e_pen   = 1'b0;
      win     = -1;
      if (!m_busy) begin
        win = rr_pick(req_valid, m_last);
        if (win >= 0) e_ready[win] = 1'b1;
      end else if (m_age == 1) begin
        e_psel = 1'b1;
      end else if (m_done_at < 0) begin
        e_psel = 1'b1;
        e_pen  = 1'b1;
      end else begin
        e_rsp[m_owner] = 1'b1;
      end

      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("psel",      32'(PSELx),     32'(e_psel));
      chk("penable",   32'(PENABLE),   32'(e_pen));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      chk("pwrite",    32'(PWRITE),    32'(m_write));
      chk("paddr",     32'(PADDR),     32'(m_paddr));
      chk("pwdata",    32'(PWDATA),    32'(m_pwdata));
      if (e_rsp != '0) begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        chk("rsp_err",   32'(rsp_err),   32'(m_err));
      end

      if (!m_busy) begin
        if (win >= 0) begin
          m_busy          = 1'b1;
          m_age           = 0;
          m_done_at       = -1;
          m_owner         = win;
          m_write         = req_write[win];
          m_paddr         = req_addr[win*ADDR_W +: ADDR_W];
          m_pwdata        = req_wdata[win*DATA_W +: DATA_W];
          m_acc_mask[win] = 1'b1;
          acc_cycle       = cyc;
          log_owner.push_back(win);
          log_acc.push_back(cyc);
        end
      end else if (m_age >= 2 && m_done_at < 0) begin
        if (PREADY) begin
          m_done_at = m_age + 1;
          m_rdata   = m_write ? '0 : PRDATA;
          m_err     = 1'b0;
        end else if (m_age - 1 == TIMEOUT) begin
          m_done_at = m_age + 1;
          m_rdata   = '0;
          m_err     = 1'b1;
        end
      end else if (m_done_at >= 0 && m_age == m_done_at) begin
        m_busy = 1'b0;
        m_last = m_owner;
        log_lat.push_back(cyc - acc_cycle);
        log_rdata.push_back(32'(m_rdata));
        log_err.push_back(32'(m_err));
        $display("txn %0d: owner=%0d write=%0d addr=%02h lat=%0d rdata=%02h err=%0d",
                 log_lat.size(), m_owner, m_write, m_paddr, cyc - acc_cycle, m_rdata, m_err);
      end
      if (m_busy) m_age++;
    end
  end

  // PREADY behaviour: 0 = always ready, 1 = three wait states then 0x3C,
  // 2 = stuck low, 3 = random.
  int pr_mode = 0;

  task automatic drive_pready();
    case (pr_mode)
      0: PREADY = 1'b1;
      1: begin
        PREADY = m_busy && (m_age >= 5);
        PRDATA = 8'h3C;
      end
      2: PREADY = 1'b0;
      default: begin
        PREADY = ($urandom_range(0, 99) < 45);
        PRDATA = 8'($urandom);
      end
    endcase
  endtask

  task automatic set_mode(input int m);
    pr_mode = m;
    drive_pready();
  endtask

  task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
    req_valid[i]                 = 1'b1;
    req_write[i]                 = w;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic step(input bit refill);
    @(negedge pclk);
    for (int i = 0; i < NREQ; i++) begin
      if (m_acc_mask[i]) begin
        if (refill) set_req(i, 1'($urandom), 8'($urandom), 8'($urandom));
        else req_valid[i] = 1'b0;
      end
    end
    drive_pready();
  endtask

  task automatic run_until(input int target, input int budget, input bit refill);
    int n;
    n = 0;
    while (log_lat.size() < target && n < budget) begin
      step(refill);
      n++;
    end
    chk("wait_budget", 32'(log_lat.size() >= target), 1);
  endtask

  int ob;
  int lb;
  int n;

  initial begin
    set_mode(0);
    repeat (3) step(1'b0);
    PRESET = 1'b0;

    // Single write from requester 0, zero wait states.
    ob = log_owner.size();
    lb = log_lat.size();
    set_req(0, 1'b1, 8'h02, 8'hA5);
    run_until(lb + 1, 20, 1'b0);
    chk("d1_owner", 32'(log_owner[ob]), 0);
    chk("d1_lat",   32'(log_lat[lb]), 3);
    chk("d1_rdata", 32'(log_rdata[lb]), 0);
    chk("d1_err",   32'(log_err[lb]), 0);
    chk("d1_paddr", 32'(PADDR), 32'h02);
    chk("d1_pwdata", 32'(PWDATA), 32'hA5);
    chk("d1_pwrite", 32'(PWRITE), 1);

    // Read from requester 1 with three wait states.
    ob = log_owner.size();
    lb = log_lat.size();
    set_mode(1);
    set_req(1, 1'b0, 8'h04, 8'h00);
    run_until(lb + 1, 30, 1'b0);
    chk("d2_owner", 32'(log_owner[ob]), 1);
    chk("d2_lat",   32'(log_lat[lb]), 6);
    chk("d2_rdata", 32'(log_rdata[lb]), 32'h3C);
    chk("d2_err",   32'(log_err[lb]), 0);

    // Both requesters always pending: strict alternation, 4 cycles apart.
    ob = log_owner.size();
    lb = log_lat.size();
    set_mode(0);
    set_req(0, 1'b1, 8'h10, 8'h01);
    set_req(1, 1'b0, 8'h11, 8'h00);
    run_until(lb + 4, 40, 1'b1);
    req_valid = '0;
    chk("d3_owner0", 32'(log_owner[ob]), 0);
    chk("d3_owner1", 32'(log_owner[ob+1]), 1);
    chk("d3_owner2", 32'(log_owner[ob+2]), 0);
    chk("d3_owner3", 32'(log_owner[ob+3]), 1);
    chk("d3_gap1", 32'(log_acc[ob+1] - log_acc[ob]), 4);
    chk("d3_gap2", 32'(log_acc[ob+2] - log_acc[ob+1]), 4);
    chk("d3_gap3", 32'(log_acc[ob+3] - log_acc[ob+2]), 4);

    // PREADY stuck low: timeout after exactly TIMEOUT access cycles.
    lb = log_lat.size();
    set_mode(2);
    set_req(0, 1'b0, 8'h30, 8'h00);
    run_until(lb + 1, 60, 1'b0);
    chk("d4_lat",   32'(log_lat[lb]), 18);
    chk("d4_err",   32'(log_err[lb]), 1);
    chk("d4_rdata", 32'(log_rdata[lb]), 0);

    lb = log_lat.size();
    ob = log_owner.size();
    set_mode(0);
    set_req(0, 1'b1, 8'h31, 8'h5A);
    run_until(lb + 1, 20, 1'b0);
    chk("d4b_owner", 32'(log_owner[ob]), 0);
    chk("d4b_lat",   32'(log_lat[lb]), 3);
    chk("d4b_err",   32'(log_err[lb]), 0);

    // Reset during ACCESS of a requester-1 transfer, then both pending.
    set_mode(2);
    set_req(1, 1'b0, 8'h40, 8'h00);
    n = 0;
    while (!(m_busy && m_age == 3) && n < 20) begin
      step(1'b0);
      n++;
    end
    chk("d5_reach_access", 32'(m_busy && m_age == 3), 1);
    lb = log_lat.size();
    PRESET = 1'b1;
    #2;
    chk("d5_async_clear", 32'({PSELx, PENABLE}), 0);
    set_req(0, 1'b1, 8'h50, 8'h77);
    set_req(1, 1'b0, 8'h51, 8'h00);
    step(1'b0);
    step(1'b0);
    chk("d5_no_rsp", 32'(log_lat.size()), 32'(lb));
    PRESET = 1'b0;
    set_mode(0);
    ob = log_owner.size();
    run_until(lb + 2, 30, 1'b0);
    chk("d5_first",  32'(log_owner[ob]), 0);
    chk("d5_second", 32'(log_owner[ob+1]), 1);

    // Randomized traffic with occasional resets.
    set_mode(3);
    for (int c = 0; c < 2000; c++) begin
      step(1'b0);
      if (PRESET) PRESET = 1'b0;
      else if ($urandom_range(0, 599) == 0) PRESET = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 9) < 3)
          set_req(i, 1'($urandom), 8'($urandom), 8'($urandom));
      end
    end

    PRESET = 1'b0;
    req_valid = '0;
    set_mode(0);
    repeat (30) step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: got no end of run, want completion (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
